// File: rtl/data_mem_ctrl.sv
`timescale 1ns/1ps
// data_mem_ctrl: two-port (A priority, B starvation-protected) sequencer for the 256x32 data RAM.
// Word stores write directly, sub-word stores read-modify-write, loads are lane-selected and extended.
module data_mem_ctrl #(
    parameter int DEPTH    = 256,
    parameter int MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_a,
    input  logic        req_b,
    input  logic        rw_a,
    input  logic        rw_b,
    input  logic [1:0]  size_a,
    input  logic [1:0]  size_b,
    input  logic        sgn_a,
    input  logic        sgn_b,
    input  logic [31:0] addr_a,
    input  logic [31:0] addr_b,
    input  logic [31:0] wdata_a,
    input  logic [31:0] wdata_b,
    output logic        ack_a,
    output logic        ack_b,
    output logic        err_a,
    output logic        err_b,
    output logic [31:0] rdata_a,
    output logic [31:0] rdata_b,
    output logic        ram_enable,
    output logic        ram_read_write,
    output logic [31:0] ram_address,
    output logic [31:0] ram_data_in,
    input  logic [31:0] ram_data_out
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int AW    = IDX_W + 2;
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);
    localparam logic [31:0]      ADDR_LIMIT = 32'(4 * DEPTH);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_CAP,
        WRITE,
        RESP
    } state_t;

    // Accepted command; the store data lives in word_q so it can be merged in place.
    typedef struct packed {
        logic          rw;
        logic [1:0]    size;
        logic          sgn;
        logic [AW-1:0] addr;
    } cmd_t;

    function automatic logic bad_request(input logic [1:0] size, input logic [31:0] addr);
        logic bad;
        bad = (size == SZ_BAD) || (addr >= ADDR_LIMIT);
        if (size == SZ_HALF && addr[0])
            bad = 1'b1;
        if (size == SZ_WORD && addr[1:0] != 2'b00)
            bad = 1'b1;
        return bad;
    endfunction

    function automatic logic [31:0] load_lane(input logic [31:0] word, input cmd_t cmd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{cmd.addr[1:0], 3'b000} +: 8];
        h = word[{cmd.addr[1], 4'b0000} +: 16];
        case (cmd.size)
            SZ_BYTE: r = {{24{cmd.sgn & b[7]}}, b};
            SZ_HALF: r = {{16{cmd.sgn & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [15:0] data,
                                               input cmd_t cmd);
        logic [31:0] r;
        r = word;
        if (cmd.size == SZ_BYTE)
            r[{cmd.addr[1:0], 3'b000} +: 8] = data[7:0];
        else
            r[{cmd.addr[1], 4'b0000} +: 16] = data;
        return r;
    endfunction

    state_t           state, state_nxt;
    cmd_t             cmd_q, cmd_sel;
    logic [31:0]      word_q;
    logic [31:0]      sel_addr, sel_wdata;
    logic [CNT_W-1:0] wait_cnt;
    logic             owner_b;
    logic             grant_a, grant_b, accept, sel_bad, resp_b;

    // Arbitration and request selection, evaluated only in IDLE.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state == IDLE) begin
            if (req_a && !(req_b && wait_cnt >= WAIT_LIMIT))
                grant_a = 1'b1;
            else if (req_b)
                grant_b = 1'b1;
        end
        sel_addr  = grant_b ? addr_b  : addr_a;
        sel_wdata = grant_b ? wdata_b : wdata_a;
        cmd_sel   = '{rw:   grant_b ? rw_b   : rw_a,
                      size: grant_b ? size_b : size_a,
                      sgn:  grant_b ? sgn_b  : sgn_a,
                      addr: sel_addr[AW-1:0]};
    end

    assign accept  = grant_a | grant_b;
    assign sel_bad = bad_request(cmd_sel.size, sel_addr);
    assign resp_b  = (state == IDLE) ? grant_b : owner_b;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt      = state;
        ram_enable     = 1'b0;
        ram_read_write = 1'b0;
        ack_a          = 1'b0;
        ack_b          = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (sel_bad)
                        state_nxt = RESP;
                    else if (cmd_sel.rw && cmd_sel.size == SZ_WORD)
                        state_nxt = WRITE;
                    else
                        state_nxt = RD;
                end
            end
            RD: begin
                ram_enable = 1'b1;
                state_nxt  = RD_CAP;
            end
            RD_CAP: state_nxt = cmd_q.rw ? WRITE : RESP;
            WRITE: begin
                ram_enable     = 1'b1;
                ram_read_write = 1'b1;
                state_nxt      = RESP;
            end
            RESP: begin
                ack_a     = !owner_b;
                ack_b     = owner_b;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Gated so that the RAM bus reads as zero whenever it is idle, including in reset.
    assign ram_address = ram_enable ? 32'(cmd_q.addr[AW-1:2]) : '0;
    assign ram_data_in = ram_read_write ? word_q : '0;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            owner_b  <= 1'b0;
            err_a    <= 1'b0;
            err_b    <= 1'b0;
            rdata_a  <= '0;
            rdata_b  <= '0;
        end else begin
            state <= state_nxt;

            // B's own transaction in flight does not count as waiting.
            if (grant_b)
                wait_cnt <= '0;
            else if (req_b && !(owner_b && state != IDLE) && wait_cnt != WAIT_LIMIT)
                wait_cnt <= wait_cnt + 1'b1;

            if (accept)
                owner_b <= grant_b;

            if (state_nxt == RESP) begin
                if (resp_b) begin
                    err_b <= (state == IDLE);
                    if (state == RD_CAP && !cmd_q.rw)
                        rdata_b <= load_lane(ram_data_out, cmd_q);
                end else begin
                    err_a <= (state == IDLE);
                    if (state == RD_CAP && !cmd_q.rw)
                        rdata_a <= load_lane(ram_data_out, cmd_q);
                end
            end
        end
    end

    // NOTE: datapath registers carry no reset; every consumer is qualified by the FSM state.
    always_ff @(posedge clk) begin
        if (accept) begin
            cmd_q  <= cmd_sel;
            word_q <= sel_wdata;
        end else if (state == RD_CAP) begin
            word_q <= merge_lane(ram_data_out, word_q[15:0], cmd_q);
        end
    end

endmodule
